// File: rtl/scan_7seg_driver.sv
// Time-multiplexed driver for an N-digit common-anode 7-segment display.
// Scans one digit per prescaler period. New values are held in a shadow
// register and committed only at the frame boundary, so a frame never tears.
module scan_7seg_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000,
  parameter int HEX_MODE   = 0,
  parameter int LZ_BLANK   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] disp_val;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic [4*NUM_DIGITS-1:0] shadow_val;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic                    tick;
  logic                    boundary;

  logic [NUM_DIGITS-1:0]   zero_from;
  logic [3:0]              nibble;
  logic                    blank;
  logic [6:0]              glyph;

  assign tick     = (cnt == CNT_MAX);
  assign boundary = tick && (idx == IDX_MAX);

  // Prescaler and digit scan index; index wraps to 0 at the frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= boundary ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Shadow capture and frame-boundary commit. A load that coincides with the
  // boundary tick bypasses the shadow wait and lands directly on the display.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      pending    <= 1'b0;
    end else if (load) begin
      shadow_val <= value;
      shadow_dp  <= dp;
      if (boundary) begin
        disp_val <= value;
        disp_dp  <= dp;
        pending  <= 1'b0;
      end else begin
        pending <= 1'b1;
      end
    end else if (boundary && pending) begin
      disp_val <= shadow_val;
      disp_dp  <= shadow_dp;
      pending  <= 1'b0;
    end
  end

  // Glyph lookup and leading-zero blanking for the digit being scanned.
  always_comb begin
    zero_from = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      zero_from[i] = ((disp_val >> (4 * i)) == '0);
    end
    nibble = 4'(disp_val >> {idx, 2'b00});
    blank  = (LZ_BLANK != 0) && (idx != '0) && zero_from[idx] && !disp_dp[idx];
    case (nibble)
      4'h0:    glyph = 7'b1000000;
      4'h1:    glyph = 7'b1111001;
      4'h2:    glyph = 7'b0100100;
      4'h3:    glyph = 7'b0110000;
      4'h4:    glyph = 7'b0011001;
      4'h5:    glyph = 7'b0010010;
      4'h6:    glyph = 7'b0000010;
      4'h7:    glyph = 7'b1111000;
      4'h8:    glyph = 7'b0000000;
      4'h9:    glyph = 7'b0010000;
      4'hA:    glyph = 7'b0001000;
      4'hB:    glyph = 7'b0000011;
      4'hC:    glyph = 7'b1000110;
      4'hD:    glyph = 7'b0100001;
      4'hE:    glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
    if (HEX_MODE == 0 && nibble > 4'd9) begin
      glyph = '1;
    end
  end

  // Registered display pins and frame pulse; disabled display is fully dark.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg        <= '1;
      dp_n       <= 1'b1;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (enable) begin
        seg  <= blank ? '1 : glyph;
        dp_n <= ~disp_dp[idx];
        an   <= ~(NUM_DIGITS'(1) << idx);
      end else begin
        seg  <= '1;
        dp_n <= 1'b1;
        an   <= '1;
      end
    end
  end

endmodule

// File: tb/tb_scan_7seg_driver.sv
// Self-checking bench for scan_7seg_driver: a HEX_MODE=1 and a HEX_MODE=0
// instance share stimulus and are compared each cycle against a reference
// model built from scan timing arithmetic and glyph tables.
module tb_scan_7seg_driver;

  localparam int N  = 4;
  localparam int CD = 4;
  localparam int FR = N * CD;

  localparam logic [6:0] GLY [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic         clk = 1'b0;
  logic         rst, enable, load;
  logic [15:0]  value;
  logic [3:0]   dp;
  logic [6:0]   seg, seg2;
  logic         dp_n, dp_n2, fd, fd2, pend, pend2;
  logic [3:0]   an, an2;

  always #5 clk = ~clk;

  scan_7seg_driver #(.NUM_DIGITS(N), .CLK_DIV(CD), .HEX_MODE(1), .LZ_BLANK(1)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .value(value), .dp(dp),
    .seg(seg), .dp_n(dp_n), .an(an), .frame_done(fd), .pending(pend)
  );

  scan_7seg_driver #(.NUM_DIGITS(N), .CLK_DIV(CD), .HEX_MODE(0), .LZ_BLANK(1)) u_dec (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .value(value), .dp(dp),
    .seg(seg2), .dp_n(dp_n2), .an(an2), .frame_done(fd2), .pending(pend2)
  );

  int vecs = 0;
  int errs = 0;

  // Reference model state: k counts clock edges since reset release.
  int          k;
  logic [15:0] m_disp, m_sh;
  logic [3:0]  m_dpv, m_shdp;
  logic        m_pend;
  logic [3:0]  e_an;
  logic [6:0]  e_seg, e_seg2;
  logic        e_dpn, e_fd;

  logic [6:0]  got_seg [4];
  logic [6:0]  got_seg2 [4];
  logic        got_dpn [4];

  function automatic logic [6:0] ref_glyph(logic [15:0] v, logic [3:0] d, int i, bit hex);
    int nib;
    nib = int'((v >> (4 * i)) % 16);
    if (i > 0 && (v >> (4 * i)) == 0 && !d[i]) return 7'h7F;
    if (nib >= 10 && !hex) return 7'h7F;
    return GLY[nib];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int idx;
    bit tick, bnd;
    if (rst) begin
      k = 0; m_disp = '0; m_dpv = '0; m_sh = '0; m_shdp = '0; m_pend = 1'b0;
      e_an = 4'hF; e_seg = 7'h7F; e_seg2 = 7'h7F; e_dpn = 1'b1; e_fd = 1'b0;
    end else begin
      idx  = (k / CD) % N;
      tick = ((k % CD) == CD - 1);
      bnd  = tick && (idx == N - 1);
      if (enable) begin
        e_an   = 4'hF ^ (4'(1) << idx);
        e_seg  = ref_glyph(m_disp, m_dpv, idx, 1'b1);
        e_seg2 = ref_glyph(m_disp, m_dpv, idx, 1'b0);
        e_dpn  = !m_dpv[idx];
      end else begin
        e_an = 4'hF; e_seg = 7'h7F; e_seg2 = 7'h7F; e_dpn = 1'b1;
      end
      e_fd = bnd;
      if (load) begin
        m_sh = value; m_shdp = dp;
        if (bnd) begin
          m_disp = value; m_dpv = dp; m_pend = 1'b0;
        end else begin
          m_pend = 1'b1;
        end
      end else if (bnd && m_pend) begin
        m_disp = m_sh; m_dpv = m_shdp; m_pend = 1'b0;
      end
      k++;
    end
  endtask

  // One clock: advance the model with the current inputs, then compare.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("an", 32'(an), 32'(e_an));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dp_n", 32'(dp_n), 32'(e_dpn));
    chk("frame_done", 32'(fd), 32'(e_fd));
    chk("pending", 32'(pend), 32'(m_pend));
    chk("seg_dec", 32'(seg2), 32'(e_seg2));
    chk("an_dec", 32'(an2), 32'(e_an));
    chk("pending_dec", 32'(pend2), 32'(m_pend));
  endtask

  task automatic sync_to(int phase);
    for (int i = 0; i < FR + 2 && (k % FR) != phase; i++) step();
  endtask

  // Run one frame and record what each anode showed.
  task automatic capture_frame();
    for (int d = 0; d < N; d++) begin
      got_seg[d] = 'x; got_seg2[d] = 'x; got_dpn[d] = 1'bx;
    end
    repeat (FR) begin
      step();
      for (int d = 0; d < N; d++) begin
        if (an === (4'hF ^ (4'(1) << d))) begin
          got_seg[d] = seg; got_seg2[d] = seg2; got_dpn[d] = dp_n;
        end
      end
    end
  endtask

  task automatic do_load(logic [15:0] v, logic [3:0] d);
    load = 1'b1; value = v; dp = d;
    step();
    load = 1'b0;
  endtask

  initial begin
    int n;
    logic [15:0] v;
    rst = 1'b1; enable = 1'b1; load = 1'b0; value = '0; dp = '0;

    // Reset held three cycles
    repeat (3) step();
    chk("reset_an", 32'(an), 32'hF);
    chk("reset_seg", 32'(seg), 32'h7F);
    rst = 1'b0;

    // Two frames after reset: one frame_done per frame, zero on digit 0 only
    n = 0;
    repeat (2 * FR) begin
      step();
      if (fd === 1'b1) n++;
    end
    chk("fd_count", 32'(n), 32'd2);
    capture_frame();
    chk("rst_d0", 32'(got_seg[0]), 32'h40);
    chk("rst_d3", 32'(got_seg[3]), 32'h7F);

    // Mid-frame load persists until the boundary, then shows 12AF
    sync_to(6);
    do_load(16'h12AF, 4'b0000);
    chk("load_pending", 32'(pend), 32'd1);
    sync_to(0);
    capture_frame();
    chk("d0_F", 32'(got_seg[0]), 32'(7'b0001110));
    chk("d1_A", 32'(got_seg[1]), 32'(7'b0001000));
    chk("d2_2", 32'(got_seg[2]), 32'(7'b0100100));
    chk("d3_1", 32'(got_seg[3]), 32'(7'b1111001));
    chk("d1_A_dec", 32'(got_seg2[1]), 32'h7F);

    // Load coinciding with the boundary tick
    sync_to(FR - 1);
    do_load(16'h0009, 4'b0000);
    chk("bnd_pending", 32'(pend), 32'd0);
    capture_frame();
    chk("bnd_d0", 32'(got_seg[0]), 32'(7'b0010000));
    chk("bnd_d1", 32'(got_seg[1]), 32'h7F);
    chk("bnd_d3", 32'(got_seg[3]), 32'h7F);

    // Decimal point keeps a zero digit from being blanked
    sync_to(5);
    do_load(16'h0005, 4'b0100);
    sync_to(0);
    capture_frame();
    chk("dp_d0", 32'(got_seg[0]), 32'(7'b0010010));
    chk("dp_d2_seg", 32'(got_seg[2]), 32'(7'b1000000));
    chk("dp_d2_dpn", 32'(got_dpn[2]), 32'd0);
    chk("dp_d3_seg", 32'(got_seg[3]), 32'h7F);
    chk("dp_d3_dpn", 32'(got_dpn[3]), 32'd1);

    // Hex nibble B: glyph on the hex instance, dark on the decimal one
    sync_to(3);
    do_load(16'h000B, 4'b0000);
    sync_to(0);
    capture_frame();
    chk("hexB", 32'(got_seg[0]), 32'(7'b0000011));
    chk("decB", 32'(got_seg2[0]), 32'h7F);

    // Display disabled: dark anodes, scanning and frame_done continue
    sync_to(0);
    enable = 1'b0;
    n = 0;
    repeat (20) begin
      step();
      chk("dis_an", 32'(an), 32'hF);
      if (fd === 1'b1) n++;
    end
    chk("dis_fd_count", 32'(n), 32'd1);
    enable = 1'b1;

    // Reset while a load is pending discards it
    sync_to(4);
    do_load(16'h1234, 4'b0011);
    chk("pre_rst_pending", 32'(pend), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_pending", 32'(pend), 32'd0);
    capture_frame();
    chk("rst2_d0", 32'(got_seg[0]), 32'h40);
    chk("rst2_d1", 32'(got_seg[1]), 32'h7F);

    // Randomized traffic against the model
    repeat (600) begin
      rst    = ($urandom % 250) == 0;
      enable = ($urandom % 8) != 0;
      load   = ($urandom % 6) == 0;
      v = '0;
      for (int i = 0; i < N; i++) begin
        if ($urandom % 2) v[4*i +: 4] = 4'($urandom % 16);
      end
      value = v;
      dp    = (($urandom % 3) == 0) ? 4'($urandom % 16) : 4'b0000;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
